// File: rtl/syn_fft_sched.sv
// syn_fft_sched: stage/butterfly sequencer for a radix-2 in-place DIT FFT.
// Optional SYN_FFT_SCHED_PERF_EN adds a saturating stall_cnt output.
module syn_fft_sched #(
    parameter int P_LOG2N    = 5,
    parameter int P_SAMPLE_W = 32,
    parameter int P_TWDL_W   = 10,
    parameter int P_Q_DEPTH  = 8
) (
    input  logic                      clk_ir,
    input  logic                      rst_ir,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      ram_rd_en,
    output logic [P_LOG2N-1:0]        ram_rd_addr,
    input  logic [2*P_SAMPLE_W-1:0]   ram_rd_data,
    output logic                      ram_wr_en,
    output logic [P_LOG2N-1:0]        ram_wr_addr,
    output logic [2*P_SAMPLE_W-1:0]   ram_wr_data,
    output logic [P_LOG2N-2:0]        twdl_addr,
    input  logic [2*P_TWDL_W-1:0]     twdl_data,
    output logic [2*P_SAMPLE_W-1:0]   but_sample_a,
    output logic [2*P_SAMPLE_W-1:0]   but_sample_b,
    output logic [2*P_TWDL_W-1:0]     but_twdl,
    output logic                      but_sample_rdy,
    input  logic [2*P_SAMPLE_W-1:0]   but_res,
    input  logic                      but_res_rdy,
    output logic                      q_err
`ifdef SYN_FFT_SCHED_PERF_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int SW = $clog2(P_LOG2N + 1);
    localparam int QW = $clog2(P_Q_DEPTH);
    localparam int DW = 2 * P_SAMPLE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_A,
        S_ISSUE_B,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [P_LOG2N-2:0]  k_q, k_d;

    logic [P_LOG2N-1:0]  k_ext, half, pos, addr_a, addr_b;
    logic [P_LOG2N-2:0]  addr_t;
    logic                last_stage;

    logic [P_LOG2N-1:0]  qa_q [P_Q_DEPTH];
    logic [P_LOG2N-1:0]  qb_q [P_Q_DEPTH];
    logic [QW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [QW:0]         cnt_q;
    logic                toggle_q;
    logic                q_full, q_empty, push, pop;

    logic                iss_b_q;
    logic [DW-1:0]       hold_a_q, samp_a_q, samp_b_q, wr_data_q;
    logic [2*P_TWDL_W-1:0] twdl_q;
    logic                samp_rdy_q, wr_en_q, q_err_q;
    logic [P_LOG2N-1:0]  wr_addr_q;

    // Butterfly k of stage s pairs A and A+2^s; twiddle index scales pos up to the N/2 grid.
    assign k_ext      = {1'b0, k_q};
    assign half       = P_LOG2N'(1) << stage_q;
    assign pos        = k_ext & (half - P_LOG2N'(1));
    assign addr_a     = ((k_ext >> stage_q) << (stage_q + SW'(1))) | pos;
    assign addr_b     = addr_a | half;
    assign addr_t     = pos[P_LOG2N-2:0] << (SW'(P_LOG2N - 1) - stage_q);
    assign last_stage = (stage_q == SW'(P_LOG2N - 1));

    assign q_full  = (cnt_q == (QW+1)'(P_Q_DEPTH));
    assign q_empty = (cnt_q == '0);
    assign push    = (state_q == S_ISSUE_B);
    assign pop     = but_res_rdy && !q_empty && toggle_q;

    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE_A;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            S_ISSUE_A: begin
                if (!q_full) state_d = S_ISSUE_B;
            end
            S_ISSUE_B: begin
                if (k_q == '1) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_ISSUE_A;
                end
            end
            S_DRAIN: begin
                if (q_empty && !wr_en_q) begin
                    if (last_stage) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        state_d = S_ISSUE_A;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        twdl_addr   = '0;
        case (state_q)
            S_ISSUE_A: begin
                if (!q_full) begin
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = addr_a;
                end
            end
            S_ISSUE_B: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = addr_b;
                twdl_addr   = addr_t;
            end
            default: ;
        endcase
    end

    // A data arrives during ISSUE_B; B data and twiddle arrive the cycle after.
    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            iss_b_q    <= 1'b0;
            hold_a_q   <= '0;
            samp_a_q   <= '0;
            samp_b_q   <= '0;
            twdl_q     <= '0;
            samp_rdy_q <= 1'b0;
        end else begin
            iss_b_q    <= (state_q == S_ISSUE_B);
            samp_rdy_q <= iss_b_q;
            if (state_q == S_ISSUE_B) hold_a_q <= ram_rd_data;
            if (iss_b_q) begin
                samp_a_q <= hold_a_q;
                samp_b_q <= ram_rd_data;
                twdl_q   <= twdl_data;
            end
        end
    end

    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            for (int unsigned i = 0; i < P_Q_DEPTH; i++) begin
                qa_q[i] <= '0;
                qb_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            toggle_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            q_err_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (push) begin
                qa_q[wr_ptr_q] <= addr_a;
                qb_q[wr_ptr_q] <= addr_b;
                wr_ptr_q       <= wr_ptr_q + 1'b1;
            end
            if (but_res_rdy) begin
                if (q_empty) begin
                    q_err_q <= 1'b1;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= but_res;
                    wr_addr_q <= toggle_q ? qb_q[rd_ptr_q] : qa_q[rd_ptr_q];
                    toggle_q  <= !toggle_q;
                    if (toggle_q) rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign but_sample_a   = samp_a_q;
    assign but_sample_b   = samp_b_q;
    assign but_twdl       = twdl_q;
    assign but_sample_rdy = samp_rdy_q;
    assign ram_wr_en      = wr_en_q;
    assign ram_wr_addr    = wr_addr_q;
    assign ram_wr_data    = wr_data_q;
    assign q_err          = q_err_q;

`ifdef SYN_FFT_SCHED_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_ir or posedge rst_ir) begin
        if (rst_ir) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (((state_q == S_ISSUE_A && q_full) || state_q == S_DRAIN) && stall_q != '1) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_syn_fft_sched.sv
// Randomised bench for syn_fft_sched: RAM/ROM/butterfly environment plus an in-place FFT schedule reference.
module tb_syn_fft_sched;

    localparam int L2N    = 5;
    localparam int SWD    = 32;
    localparam int TWW    = 10;
    localparam int QD     = 8;
    localparam int N      = 1 << L2N;
    localparam int NB     = N / 2;
    localparam int TOTB   = L2N * NB;
    localparam int DW     = 2 * SWD;
    localparam int RING   = 128;
    localparam int BUDGET = 20000;

    logic              clk_ir = 1'b0;
    logic              rst_ir;
    logic              start;
    logic              busy, done;
    logic              ram_rd_en;
    logic [L2N-1:0]    ram_rd_addr;
    logic [DW-1:0]     ram_rd_data;
    logic              ram_wr_en;
    logic [L2N-1:0]    ram_wr_addr;
    logic [DW-1:0]     ram_wr_data;
    logic [L2N-2:0]    twdl_addr;
    logic [2*TWW-1:0]  twdl_data;
    logic [DW-1:0]     but_sample_a, but_sample_b;
    logic [2*TWW-1:0]  but_twdl;
    logic              but_sample_rdy;
    logic [DW-1:0]     but_res;
    logic              but_res_rdy;
    logic              q_err;
`ifdef SYN_FFT_SCHED_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    syn_fft_sched #(
        .P_LOG2N   (L2N),
        .P_SAMPLE_W(SWD),
        .P_TWDL_W  (TWW),
        .P_Q_DEPTH (QD)
    ) dut (
        .clk_ir        (clk_ir),
        .rst_ir        (rst_ir),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .twdl_addr     (twdl_addr),
        .twdl_data     (twdl_data),
        .but_sample_a  (but_sample_a),
        .but_sample_b  (but_sample_b),
        .but_twdl      (but_twdl),
        .but_sample_rdy(but_sample_rdy),
        .but_res       (but_res),
        .but_res_rdy   (but_res_rdy),
        .q_err         (q_err)
`ifdef SYN_FFT_SCHED_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk_ir = ~clk_ir;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]    mem     [N];
    logic [DW-1:0]    ref_mem [N];
    int               exp_a   [TOTB];
    int               exp_b   [TOTB];
    int               exp_t   [TOTB];
    logic [DW-1:0]    exp_av  [TOTB];
    logic [DW-1:0]    exp_bv  [TOTB];
    logic [2*TWW-1:0] exp_tw  [TOTB];
    logic [DW-1:0]    exp_r0  [TOTB];
    logic [DW-1:0]    exp_r1  [TOTB];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2*TWW-1:0] rom(input int t);
        logic [TWW-1:0] re, im;
        re = TWW'(t * 37 + 5);
        im = TWW'(t) ^ 10'h2aa;
        return {re, im};
    endfunction

    function automatic logic [DW-1:0] bf0(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [2*TWW-1:0] w);
        return a + (b ^ DW'(w));
    endfunction

    function automatic logic [DW-1:0] bf1(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [2*TWW-1:0] w);
        return a - b + DW'(w);
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom};
    endtask

    // Plain in-place DIT schedule: pair spacing 2^s, twiddle step N/2^(s+1).
    task automatic build_ref();
        int idx, half, pos;
        idx = 0;
        for (int i = 0; i < N; i++) ref_mem[i] = mem[i];
        for (int s = 0; s < L2N; s++) begin
            half = 2 ** s;
            for (int k = 0; k < NB; k++) begin
                pos          = k % half;
                exp_a[idx]   = (k / half) * 2 * half + pos;
                exp_b[idx]   = exp_a[idx] + half;
                exp_t[idx]   = pos * (NB / half);
                exp_av[idx]  = ref_mem[exp_a[idx]];
                exp_bv[idx]  = ref_mem[exp_b[idx]];
                exp_tw[idx]  = rom(exp_t[idx]);
                exp_r0[idx]  = bf0(exp_av[idx], exp_bv[idx], exp_tw[idx]);
                exp_r1[idx]  = bf1(exp_av[idx], exp_bv[idx], exp_tw[idx]);
                ref_mem[exp_a[idx]] = exp_r0[idx];
                ref_mem[exp_b[idx]] = exp_r1[idx];
                idx++;
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_wr_addr", ram_wr_addr, 0);
        check("rst_wr_data", ram_wr_data, 0);
        check("rst_twdl_addr", twdl_addr, 0);
        check("rst_smp_rdy", but_sample_rdy, 0);
        check("rst_smp_a", but_sample_a, 0);
        check("rst_smp_b", but_sample_b, 0);
        check("rst_smp_twdl", but_twdl, 0);
        check("rst_q_err", q_err, 0);
    endtask

    task automatic run_fft(input int lat, input bit extra_start, input bit abort_s1, input bit expect_fill);
        int cyc, rd_idx, rdy_idx, wr_idx, res_idx, done_cnt;
        int pushes, pops, max_out, stall_obs, bf, slot, prev_rd_addr, prev_tw;
        bit prev_rd_en, done_seen, finished;
        int a_cyc  [TOTB];
        int rr_cyc [2*TOTB];
        bit res_v  [RING];
        logic [DW-1:0] res_d [RING];

        cyc = 0; rd_idx = 0; rdy_idx = 0; wr_idx = 0; res_idx = 0; done_cnt = 0;
        pushes = 0; pops = 0; max_out = 0; stall_obs = 0; prev_rd_addr = 0; prev_tw = 0;
        prev_rd_en = 0; done_seen = 0; finished = 0;
        for (int i = 0; i < TOTB; i++) a_cyc[i] = 0;
        for (int i = 0; i < 2*TOTB; i++) rr_cyc[i] = 0;
        for (int i = 0; i < RING; i++) begin
            res_v[i] = 0;
            res_d[i] = '0;
        end

        @(posedge clk_ir); #1;
        start = 1'b1;
        while (!finished && cyc < BUDGET) begin
            @(posedge clk_ir); #1;
            cyc++;
            start       = extra_start && (cyc == 20);
            ram_rd_data = prev_rd_en ? mem[prev_rd_addr] : '0;
            twdl_data   = rom(prev_tw);
            slot        = cyc % RING;
            but_res_rdy = res_v[slot];
            but_res     = res_d[slot];
            res_v[slot] = 0;
            if (but_res_rdy) begin
                if (res_idx < 2*TOTB) rr_cyc[res_idx] = cyc;
                if (res_idx % 2 == 1) pops++;
                res_idx++;
            end

            if (done_seen) begin
                check("busy_after_done", busy, 0);
                finished = 1;
            end

            if (ram_rd_en) begin
                if (rd_idx >= 2*TOTB) begin
                    check("rd_overrun", rd_idx, 2*TOTB - 1);
                end else begin
                    bf = rd_idx / 2;
                    if (rd_idx % 2 == 0) begin
                        check("rd_addr_a", ram_rd_addr, exp_a[bf]);
                        a_cyc[bf] = cyc;
                        if (bf % NB == 0) check("stage_barrier", wr_idx, 2 * bf);
                    end else begin
                        check("rd_addr_b", ram_rd_addr, exp_b[bf]);
                        check("twdl_addr", twdl_addr, exp_t[bf]);
                        pushes++;
                    end
                end
                rd_idx++;
            end
            prev_rd_en   = ram_rd_en;
            prev_rd_addr = ram_rd_addr;
            prev_tw      = twdl_addr;

            if (busy && !ram_rd_en && !done) stall_obs++;

            if (but_sample_rdy) begin
                if (rdy_idx >= TOTB) begin
                    check("rdy_overrun", rdy_idx, TOTB - 1);
                end else begin
                    check("op_a", but_sample_a, exp_av[rdy_idx]);
                    check("op_b", but_sample_b, exp_bv[rdy_idx]);
                    check("op_twdl", but_twdl, exp_tw[rdy_idx]);
                    check("op_latency", cyc - a_cyc[rdy_idx], 3);
                end
                res_v[(cyc + lat) % RING]     = 1;
                res_d[(cyc + lat) % RING]     = bf0(but_sample_a, but_sample_b, but_twdl);
                res_v[(cyc + lat + 1) % RING] = 1;
                res_d[(cyc + lat + 1) % RING] = bf1(but_sample_a, but_sample_b, but_twdl);
                rdy_idx++;
            end

            if (ram_wr_en) begin
                if (wr_idx >= 2*TOTB) begin
                    check("wr_overrun", wr_idx, 2*TOTB - 1);
                end else begin
                    bf = wr_idx / 2;
                    check("wr_addr", ram_wr_addr, (wr_idx % 2 == 0) ? exp_a[bf] : exp_b[bf]);
                    check("wr_data", ram_wr_data, (wr_idx % 2 == 0) ? exp_r0[bf] : exp_r1[bf]);
                    check("wr_latency", cyc - rr_cyc[wr_idx], 1);
                end
                mem[ram_wr_addr] = ram_wr_data;
                wr_idx++;
            end

            if (pushes - pops > max_out) max_out = pushes - pops;

            if (done && !done_seen) begin
                done_cnt++;
                check("busy_at_done", busy, 1);
`ifdef SYN_FFT_SCHED_PERF_EN
                check("stall_cnt", stall_cnt, stall_obs);
                check("stall_cnt_nz", stall_cnt != 0, 1);
`endif
                done_seen = 1;
            end

            if (abort_s1 && rd_idx == 2*NB + 6) begin
                #2 rst_ir = 1'b1;
                start       = 1'b0;
                but_res_rdy = 1'b0;
                @(posedge clk_ir); #1;
                check_reset_outputs();
                rst_ir = 1'b0;
                return;
            end
        end

        start       = 1'b0;
        but_res_rdy = 1'b0;
        check("run_finished", finished, 1);
        check("done_count", done_cnt, 1);
        check("read_count", rd_idx, 2*TOTB);
        check("rdy_count", rdy_idx, TOTB);
        check("write_count", wr_idx, 2*TOTB);
        check("queue_bound", max_out <= QD, 1);
        if (expect_fill) check("queue_fill", max_out, QD);
        for (int i = 0; i < N; i++) check("final_mem", mem[i], ref_mem[i]);
    endtask

    initial begin
        rst_ir      = 1'b1;
        start       = 1'b0;
        ram_rd_data = '0;
        twdl_data   = '0;
        but_res     = '0;
        but_res_rdy = 1'b0;
        repeat (3) @(posedge clk_ir);
        #1;
        check_reset_outputs();
        rst_ir = 1'b0;

        // Short butterfly latency, with a start pulse mid-run that must be ignored.
        fill_mem(); build_ref();
        run_fft(5, 1'b1, 1'b0, 1'b0);
        check("q_err_after_run", q_err, 0);

        // Long latency fills the address-pair queue and forces ISSUE_A stalls.
        fill_mem(); build_ref();
        run_fft(40, 1'b0, 1'b0, 1'b1);

        fill_mem(); build_ref();
        run_fft($urandom_range(1, 12), 1'b0, 1'b0, 1'b0);

        // Result strobe with nothing outstanding.
        @(posedge clk_ir); #1;
        check("q_err_idle", q_err, 0);
        but_res     = {$urandom, $urandom};
        but_res_rdy = 1'b1;
        @(posedge clk_ir); #1;
        but_res_rdy = 1'b0;
        check("spurious_wr_en", ram_wr_en, 0);
        check("q_err_set", q_err, 1);
        @(posedge clk_ir); #1;
        check("q_err_sticky", q_err, 1);

        rst_ir = 1'b1;
        @(posedge clk_ir); #1;
        rst_ir = 1'b0;
        check_reset_outputs();

        // Abort partway through stage 1, then a full run must restart from stage 0.
        fill_mem(); build_ref();
        run_fft(7, 1'b0, 1'b1, 1'b0);
        fill_mem(); build_ref();
        run_fft(5, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
